// File: rtl/reg_write_arbiter.sv
// Write-port arbiter for the CPU register bank (A, X, Y, SP): grants one held request per cycle.
// Round-robin by default; define REG_ARB_FIXED_PRI_EN for fixed priority (lowest index wins).

`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

module reg_write_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int REG_WIDTH = `REG_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [2*NUM_REQ-1:0]         sel,
  input  logic [REG_WIDTH*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [3:0]                   reg_we,
  output logic [REG_WIDTH-1:0]         reg_din,
  output logic                         busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [NUM_REQ-1:0]   eligible;
  logic                 found;
  int                   win;
  int                   elig_cnt;
  logic [1:0]           win_sel;
  logic [REG_WIDTH-1:0] win_data;

  // A requester currently holding the grant is still showing its stale request; mask it.
  assign eligible = req & ~gnt & {NUM_REQ{en}};

`ifdef REG_ARB_FIXED_PRI_EN
  always_comb begin
    found    = 1'b0;
    win      = 0;
    elig_cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (eligible[i]) begin
        elig_cnt = elig_cnt + 1;
        if (!found) begin
          found = 1'b1;
          win   = i;
        end
      end
    end
    win_sel  = sel[2*win +: 2];
    win_data = wdata[REG_WIDTH*win +: REG_WIDTH];
  end
`else
  logic [PTR_W-1:0] ptr;
  int               idx;

  // Search ascends from ptr and wraps, so the most recent winner is visited last.
  always_comb begin
    found    = 1'b0;
    win      = 0;
    elig_cnt = 0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (eligible[i]) elig_cnt = elig_cnt + 1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_sel  = sel[2*win +: 2];
    win_data = wdata[REG_WIDTH*win +: REG_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      if (win == NUM_REQ - 1) ptr <= '0;
      else                    ptr <= PTR_W'(win + 1);
    end
  end
`endif

  // reg_din deliberately holds its last value when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt     <= '0;
      reg_we  <= '0;
      reg_din <= '0;
      busy    <= 1'b0;
    end else begin
      busy <= (elig_cnt > 1);
      if (found) begin
        gnt     <= ONE << win;
        reg_we  <= 4'b0001 << win_sel;
        reg_din <= win_data;
      end else begin
        gnt    <= '0;
        reg_we <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural A/X/Y/SP register bank on the write port.
// Build with REG_ARB_FIXED_PRI_EN defined to exercise the fixed-priority variant instead.

module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [2:0]  req;
  logic [5:0]  sel;
  logic [23:0] wdata;
  logic [2:0]  gnt;
  logic [3:0]  reg_we;
  logic [7:0]  reg_din;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] bank [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

  typedef struct {
    logic        rst;
    logic        en;
    logic [2:0]  req;
    logic [5:0]  sel;
    logic [23:0] wdata;
    logic [2:0]  gnt;
    logic [3:0]  we;
    logic [7:0]  din;
    logic        busy;
    int          chk_reg;
    logic [7:0]  reg_val;
  } vec_t;

  vec_t vecs[$];

  reg_write_arbiter #(.NUM_REQ(3), .REG_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .sel(sel), .wdata(wdata),
    .gnt(gnt), .reg_we(reg_we), .reg_din(reg_din), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register bank stand-in: a write in flight when reset hits must not land.
  always @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < 4; j++) begin
        if (reg_we[j]) bank[j] <= reg_din;
      end
    end
  end

  task automatic add(input logic r, input logic e, input logic [2:0] rq, input logic [5:0] s,
                     input logic [23:0] wd, input logic [2:0] g, input logic [3:0] w,
                     input logic [7:0] d, input logic b, input int cr, input logic [7:0] rv);
    vec_t v;
    v.rst = r; v.en = e; v.req = rq; v.sel = s; v.wdata = wd;
    v.gnt = g; v.we = w; v.din = d; v.busy = b; v.chk_reg = cr; v.reg_val = rv;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset = v.rst;
    en    = v.en;
    req   = v.req;
    sel   = v.sel;
    wdata = v.wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic checkInvariants(input string tag);
    checkOutput({tag, " we_onehot0"}, {31'd0, $onehot0(reg_we)}, 32'd1);
    checkOutput({tag, " we_iff_gnt"}, {31'd0, (reg_we != 4'd0)}, {31'd0, $onehot(gnt)});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    reset = 1'b1; en = 1'b1; req = 3'b000; sel = '0; wdata = '0;

`ifdef REG_ARB_FIXED_PRI_EN
    add(1,1,3'b111,6'h24,24'h332211, 3'b000,4'b0000,8'h00,0, -1,8'h00);
    add(1,1,3'b111,6'h24,24'h332211, 3'b000,4'b0000,8'h00,0, -1,8'h00);
    add(0,1,3'b111,6'h24,24'h332211, 3'b001,4'b0001,8'h11,1, -1,8'h00);
    add(0,1,3'b111,6'h24,24'h332211, 3'b010,4'b0010,8'h22,1, -1,8'h00);
    add(0,1,3'b111,6'h24,24'h332211, 3'b001,4'b0001,8'h11,1,  1,8'h22);
    add(0,1,3'b111,6'h24,24'h332211, 3'b010,4'b0010,8'h22,1,  0,8'h11);
    add(0,1,3'b100,6'h24,24'h332211, 3'b100,4'b0100,8'h33,0, -1,8'h00);
    add(0,1,3'b000,6'h24,24'h332211, 3'b000,4'b0000,8'h33,0,  2,8'h33);
`else
    // Reset with all requesting, then round-robin 0,1,2,0,1,2.
    add(1,1,3'b111,6'h24,24'h332211, 3'b000,4'b0000,8'h00,0, -1,8'h00);
    add(1,1,3'b111,6'h24,24'h332211, 3'b000,4'b0000,8'h00,0, -1,8'h00);
    add(0,1,3'b111,6'h24,24'h332211, 3'b001,4'b0001,8'h11,1, -1,8'h00);
    add(0,1,3'b111,6'h24,24'h332211, 3'b010,4'b0010,8'h22,1, -1,8'h00);
    add(0,1,3'b111,6'h24,24'h332211, 3'b100,4'b0100,8'h33,1, -1,8'h00);
    add(0,1,3'b111,6'h24,24'h332211, 3'b001,4'b0001,8'h11,1, -1,8'h00);
    add(0,1,3'b111,6'h24,24'h332211, 3'b010,4'b0010,8'h22,1, -1,8'h00);
    add(0,1,3'b111,6'h24,24'h332211, 3'b100,4'b0100,8'h33,1, -1,8'h00);
    add(0,1,3'b000,6'h24,24'h332211, 3'b000,4'b0000,8'h33,0,  2,8'h33);
    // Requesters 0 and 2 both target A.
    add(0,1,3'b101,6'h00,24'h020001, 3'b001,4'b0001,8'h01,1, -1,8'h00);
    add(0,1,3'b100,6'h00,24'h020001, 3'b100,4'b0001,8'h02,0,  0,8'h01);
    add(0,1,3'b000,6'h00,24'h020001, 3'b000,4'b0000,8'h02,0,  0,8'h02);
    // Single write of A5 to Y.
    add(0,1,3'b010,6'h08,24'h00A500, 3'b010,4'b0100,8'hA5,0, -1,8'h00);
    add(0,1,3'b000,6'h08,24'h00A500, 3'b000,4'b0000,8'hA5,0,  2,8'hA5);
    // Issue disabled for three cycles, then enabled with ptr at 2.
    add(0,0,3'b011,6'h04,24'h007766, 3'b000,4'b0000,8'hA5,0, -1,8'h00);
    add(0,0,3'b011,6'h04,24'h007766, 3'b000,4'b0000,8'hA5,0, -1,8'h00);
    add(0,0,3'b011,6'h04,24'h007766, 3'b000,4'b0000,8'hA5,0,  1,8'h22);
    add(0,1,3'b011,6'h04,24'h007766, 3'b001,4'b0001,8'h66,1, -1,8'h00);
    add(0,1,3'b010,6'h04,24'h007766, 3'b010,4'b0010,8'h77,0,  0,8'h66);
    add(0,1,3'b000,6'h04,24'h007766, 3'b000,4'b0000,8'h77,0,  1,8'h77);
    // Reset lands while requester 2 holds the grant to SP.
    add(0,1,3'b100,6'h30,24'h990000, 3'b100,4'b1000,8'h99,0, -1,8'h00);
    add(1,1,3'b100,6'h30,24'h990000, 3'b000,4'b0000,8'h00,0,  3,8'h00);
    add(0,1,3'b100,6'h30,24'h990000, 3'b100,4'b1000,8'h99,0, -1,8'h00);
    add(0,1,3'b000,6'h30,24'h990000, 3'b000,4'b0000,8'h99,0,  3,8'h99);
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d gnt", i),     gnt,     vecs[i].gnt);
      checkOutput($sformatf("v%0d reg_we", i),  reg_we,  vecs[i].we);
      checkOutput($sformatf("v%0d reg_din", i), reg_din, vecs[i].din);
      checkOutput($sformatf("v%0d busy", i),    busy,    vecs[i].busy);
      checkInvariants($sformatf("v%0d", i));
      if (vecs[i].chk_reg >= 0)
        checkOutput($sformatf("v%0d bank%0d", i, vecs[i].chk_reg), bank[vecs[i].chk_reg], vecs[i].reg_val);
    end

`ifndef REG_ARB_FIXED_PRI_EN
    // Held requests survive an en=0 gap mid-burst and are issued once en returns.
    req = 3'b110; sel = 6'h24; wdata = 24'hBBAA00; en = 1'b1;
    waited = 0;
    do begin
      @(posedge clk); #1; waited++;
    end while (gnt == 3'b000 && waited < 8);
    checkOutput("seq first gnt", gnt, 3'b010);
    checkOutput("seq first latency", waited, 1);
    checkOutput("seq first din", reg_din, 8'hAA);
    req = 3'b100; en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("seq en0 gnt c%0d", c), gnt, 3'b000);
      checkInvariants("seq en0");
    end
    en = 1'b1;
    waited = 0;
    do begin
      @(posedge clk); #1; waited++;
    end while (gnt[2] !== 1'b1 && waited < 8);
    checkOutput("seq pending latency", waited, 1);
    checkOutput("seq pending we", reg_we, 4'b0100);
    checkOutput("seq pending din", reg_din, 8'hBB);
    req = 3'b000;
    @(posedge clk); #1;
    checkOutput("seq idle gnt", gnt, 3'b000);
    checkOutput("seq X value", bank[1], 8'hAA);
    checkOutput("seq Y value", bank[2], 8'hBB);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

- Shares the single write port of the CPU register bank (A, X, Y, SP instances of `register`) between `NUM_REQ` requesters, e.g. ALU result, memory load, and transfer/stack unit.
- Accepts held request/data pairs and grants one per cycle, round-robin by default.
- Drives one-hot write enables and shared write data into the register instances.
- Sits between the CPU execution units and the register bank.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters, 2..8.
- `REG_WIDTH`, `` `REG_WIDTH `` (8): data width.

Ports:
- `clk`  in  1: CPU clock. All state changes on the rising edge.
- `reset`  in  1: synchronous reset, active-high.
- `en`  in  1: issue enable. When low, no grants are issued.
- `req`  in  `NUM_REQ`: write request, one bit per requester.
- `sel`  in  `2*NUM_REQ`: target register per requester (bits [2i+1:2i]); 0=A, 1=X, 2=Y, 3=SP.
- `wdata`  in  `REG_WIDTH*NUM_REQ`: write data per requester (slice i).
- `gnt`  out  `NUM_REQ`: one-hot grant pulse, registered.
- `reg_we`  out  4: one-hot write enable to A/X/Y/SP `register.we`, registered.
- `reg_din`  out  `REG_WIDTH`: shared write data to `register.din`, registered.
- `busy`  out  1: at least one eligible request lost arbitration at the last edge, registered.

## Operation
Handshake:
- A requester raises `req[i]` with `sel`/`wdata` stable and holds all three until it sees `gnt[i]`=1.
- It drops `req[i]` at the next edge unless it has a new write.

Eligibility:
- `req[i]` is eligible at an edge when `en`=1 and `gnt[i]` is currently 0.
- This masks the stale request during the grant cycle.
- Consequence: the same requester can win at most every other cycle.

Arbitration at each edge:
- Among eligible requests, pick the winner w by round-robin.
- Search starts at pointer `ptr`, ascends, and wraps from `NUM_REQ-1` to 0.
- Then `gnt` <= one-hot(w), `reg_we` <= one-hot(`sel[w]`), `reg_din` <= `wdata[w]`, and `ptr` <= (w+1) mod `NUM_REQ`.

No eligible request (or `en`=0):
- `gnt` <= 0, `reg_we` <= 0, `reg_din` holds its value, `ptr` holds.

Other rules:
- `busy` <= 1 when the count of eligible requests is >1; otherwise 0.
- Two requesters targeting the same register are serialised in grant order; the later write wins.
- No data transformation; `reg_din` is a straight copy of the winner's `wdata`, full `REG_WIDTH`.
- State is `ptr`, `gnt`, `reg_we`, `reg_din`, and `busy`. There is no other FSM; the `gnt` register acts as the grant-cycle state.

## Timing
Reset, while `reset`=1 at an edge:
- `gnt`=0, `reg_we`=0, `reg_din`=0, `busy`=0, `ptr`=0.
- All requests are ignored.
- Requests still held after release are arbitrated from `ptr`=0 at the first edge with `reset`=0.
- A grant in flight when reset hits is cancelled: no write occurs. The requester keeps `req` high and is re-granted after reset.

Latency:
- `req[i]` is sampled at edge k; `gnt[i]`, `reg_we`, and `reg_din` are valid during cycle k..k+1.
- The target register's `dout` updates at edge k+1.

Throughput and `en`:
- Throughput is one write per cycle when at least two requesters alternate.
- `en` is sampled at the edge. Deasserting it mid-burst stops issue at that edge; outstanding requests stay pending, with nothing lost.
- Only one `reg_we` bit is ever high, and only in cycles where exactly one `gnt` bit is high.

## Configuration
- `REG_ARB_FIXED_PRI_EN` defined: fixed priority, lowest eligible index wins.
  - `ptr` is not implemented.
  - The every-other-cycle masking still applies, so requester 0 cannot starve others completely.
- `REG_ARB_FIXED_PRI_EN` undefined (default): round-robin as in Operation.

## Test plan
- **Reset:** hold `reset`=1 for 2 cycles with `req`=3'b111 → all outputs 0. After release, first grant is `gnt`=3'b001 carrying requester 0 data.
- **Single write:** req[1]=1, sel[1]=2 (Y), wdata[1]=8'hA5 at edge 0 → cycle 0: `gnt`=3'b010, `reg_we`=4'b0100, `reg_din`=8'hA5. Y `dout`=8'hA5 after edge 1. Requester drops `req` → no further grant.
- **Round-robin:** `req`=3'b111 held constantly, distinct `wdata` 8'h11/8'h22/8'h33 → grant order 0,1,2,0,1,2. `busy`=1 while ≥2 are eligible. No requester granted on consecutive cycles.
- **Same-register collision:** req0 and req2 both target A with 8'h01 and 8'h02, same edge → grants 0 then 2. A ends at 8'h02.
- **en gating:** `req`=3'b011, `en`=0 for 3 cycles → `gnt`=0, `reg_we`=0, register values unchanged. Raising `en` → grant at the next edge.
- **Reset mid-grant:** assert `reset` in the cycle `gnt`=3'b100 → no write to target, `ptr`=0. Requester 2 is re-granted after release once requesters 0 and 1 are idle.
- **Fixed-priority build** (`REG_ARB_FIXED_PRI_EN` defined): `req`=3'b111 held → order 0,1,0,1…. Requester 2 is granted only in cycles where both 0 and 1 are masked or idle.
